// File: rtl/muldiv_pkg.sv
// Shared types and opcode classification helpers for the multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_MADD  = 4'd2,
      OP_MADDU = 4'd3,
      OP_MSUB  = 4'd4,
      OP_MSUBU = 4'd5,
      OP_DIV   = 4'd6,
      OP_DIVU  = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } muldiv_state_t;

   function automatic logic is_mul(input muldiv_op_t op);
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_div(input muldiv_op_t op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

   function automatic logic is_signed(input muldiv_op_t op);
      return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
   endfunction

   function automatic logic is_acc(input muldiv_op_t op);
      return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_sub(input muldiv_op_t op);
      return op inside {OP_MSUB, OP_MSUBU};
   endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// Combinational restoring divide step resolving DIV_BITS quotient bits, MSB first.
module muldiv_divstep #(
   parameter int WIDTH    = 32,
   parameter int DIV_BITS = 1
) (
   input  logic [WIDTH-1:0]    rem_i,
   input  logic [DIV_BITS-1:0] bits_i,
   input  logic [WIDTH-1:0]    dvs_i,
   output logic [WIDTH-1:0]    rem_o,
   output logic [DIV_BITS-1:0] q_o
);

   logic [WIDTH:0] r;

   // With a zero divisor every trial succeeds, so the remainder simply collects the dividend.
   always_comb begin
      r   = {1'b0, rem_i};
      q_o = '0;
      for (int i = DIV_BITS - 1; i >= 0; i--) begin
         r = {r[WIDTH-1:0], bits_i[i]};
         if (r >= {1'b0, dvs_i}) begin
            r      = r - {1'b0, dvs_i};
            q_o[i] = 1'b1;
         end
      end
      rem_o = r[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, accumulate modes and flush.
// Handshake: an edge with Start & Ready & ~Flush accepts Op/A/B; Done pulses with the HI/LO write.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2,
   parameter int DIV_BITS   = 1
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Ready,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int NITER = WIDTH / DIV_BITS;
   localparam int CMAX  = (NITER > MUL_STAGES) ? NITER : MUL_STAGES;
   localparam int CW    = $clog2(CMAX + 1);

   if (WIDTH % DIV_BITS != 0) begin : g_bad_div_bits
      $error("muldiv_unit: WIDTH must be a multiple of DIV_BITS");
   end
   if (MUL_STAGES < 1) begin : g_bad_mul_stages
      $error("muldiv_unit: MUL_STAGES must be at least 1");
   end

   muldiv_state_t    state_q, state_d;
   muldiv_op_t       op_q, op_d, op_in;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dvs_q, dvs_d;
   logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
   logic             done_q, done_d, divzero_q, divzero_d;
   logic [2*WIDTH-1:0] pipe_q [MUL_STAGES];
   logic [2*WIDTH-1:0] pipe_d [MUL_STAGES];

   logic               accept, sgn_in;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod_in, mul_res;
   logic [WIDTH-1:0]   abs_a, abs_b, step_rem, q_fix, r_fix;
   logic [DIV_BITS-1:0] step_q;

   assign op_in   = muldiv_op_t'(Op);
   assign accept  = (state_q == ST_IDLE) && Start && !Flush;
   assign sgn_in  = is_signed(op_in);
   assign ext_a   = sgn_in ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
   assign ext_b   = sgn_in ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
   assign prod_in = ext_a * ext_b;
   assign abs_a   = (sgn_in && A[WIDTH-1]) ? -A : A;
   assign abs_b   = (sgn_in && B[WIDTH-1]) ? -B : B;
   assign q_fix   = negq_q ? -dvd_q : dvd_q;
   assign r_fix   = negr_q ? -rem_q : rem_q;

   // Accumulate base is the live HI/LO, which is frozen while the unit is busy.
   always_comb begin
      mul_res = pipe_q[MUL_STAGES-1];
      if (is_sub(op_q))      mul_res = {hi_q, lo_q} - pipe_q[MUL_STAGES-1];
      else if (is_acc(op_q)) mul_res = {hi_q, lo_q} + pipe_q[MUL_STAGES-1];
   end

   muldiv_divstep #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) u_divstep (
      .rem_i  (rem_q),
      .bits_i (dvd_q[WIDTH-1 -: DIV_BITS]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem),
      .q_o    (step_q)
   );

   always_comb begin
      pipe_d[0] = (accept && is_mul(op_in)) ? prod_in : pipe_q[0];
      for (int i = 1; i < MUL_STAGES; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d = op_in;
               if (is_mul(op_in)) begin
                  state_d = ST_MUL;
                  cnt_d   = CW'(MUL_STAGES - 1);
               end else if (is_div(op_in)) begin
                  state_d = ST_DIV;
                  cnt_d   = CW'(NITER - 1);
                  dvd_d   = abs_a;
                  dvs_d   = abs_b;
                  rem_d   = '0;
                  negq_d  = sgn_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                  negr_d  = sgn_in && A[WIDTH-1];
                  dz_d    = (B == '0);
               end else if (op_in == OP_MTHI) begin
                  hi_d = A;
               end else if (op_in == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         ST_MUL: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d      = ST_IDLE;
               {hi_d, lo_d} = mul_res;
               done_d       = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DIV: begin
            if (Flush) begin
               state_d = ST_IDLE;
            end else begin
               dvd_d = (dvd_q << DIV_BITS) | WIDTH'(step_q);
               rem_d = step_rem;
               if (cnt_q == '0) state_d = ST_FIX;
               else             cnt_d   = cnt_q - CW'(1);
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!Flush) begin
               hi_d      = r_fix;
               lo_d      = dz_q ? '1 : q_fix;
               done_d    = 1'b1;
               divzero_d = dz_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULT;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dvd_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         negq_q    <= negq_d;
         negr_q    <= negr_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
         for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign Ready   = (state_q == ST_IDLE);
   assign Done    = done_q;
   assign DivZero = divzero_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule
